// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified instruction/data memory port arbiter:
// FSM state codes, memory access codes and the starvation counter width.
package mem_port_arbiter_pkg;
  localparam int ARB_STATE_WIDTH = 2;
  localparam logic [ARB_STATE_WIDTH-1:0] ARB_IDLE   = 2'd0;
  localparam logic [ARB_STATE_WIDTH-1:0] ARB_BUSY_I = 2'd1;
  localparam logic [ARB_STATE_WIDTH-1:0] ARB_BUSY_D = 2'd2;

  localparam int MEM_ACCESS_WIDTH = 3;
  localparam logic [MEM_ACCESS_WIDTH-1:0] MEM_ACCESS_WORD = 3'b010;

  localparam int WAIT_WIDTH = 4;

  typedef logic [MEM_ACCESS_WIDTH-1:0] mem_access_t;
endpackage

// File: rtl/mem_port_arbiter_starvation_counter.sv
// Saturating count of consecutive cycles a fetch request has waited without
// a grant; the saturated flag lets fetch win a tie against data.
module starvation_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  inc,
  input  logic                  clr,
  output logic [WAIT_WIDTH-1:0] count,
  output logic                  saturated
);
  assign saturated = (count == WAIT_WIDTH'(MAX_WAIT));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && !saturated) begin
      count <= count + WAIT_WIDTH'(1);
    end
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store.
// One transaction outstanding at a time; data wins ties unless fetch has starved.
//
// Handshake: a requester raises xReq and holds its request fields stable until
// xGnt pulses (issue cycle). xValid pulses LATENCY+1 cycles after xGnt, with
// xData updated for fetches/loads; a req still high after its gnt is a new one.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int N        = 32,
  parameter int LATENCY  = 1,
  parameter int MAX_WAIT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       iReq,
  input  logic [N-1:0]               iAddr,
  output logic                       iGnt,
  output logic                       iValid,
  output logic [N-1:0]               iData,
  input  logic                       dReq,
  input  logic                       dWe,
  input  logic [N-1:0]               dAddr,
  input  logic [N-1:0]               dWrData,
  input  mem_access_t                dAccess,
  output logic                       dGnt,
  output logic                       dValid,
  output logic [N-1:0]               dData,
  output logic                       memRdEna,
  output logic                       memWrEna,
  output logic [N-1:0]               memAddr,
  output logic [N-1:0]               memWrData,
  output mem_access_t                memAccess,
  input  logic [N-1:0]               memRdData,
  output logic [ARB_STATE_WIDTH-1:0] dbg_state,
  output logic [WAIT_WIDTH-1:0]      dbg_wait
);
  localparam logic [2:0] LAT = 3'(LATENCY);

  logic [ARB_STATE_WIDTH-1:0] state;
  logic [2:0]                 lat_cnt;
  logic                       d_store;
  logic                       wait_sat;

  starvation_counter #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk       (clk),
    .rst       (rst),
    .inc       (iReq && !iGnt),
    .clr       (iGnt || !iReq),
    .count     (dbg_wait),
    .saturated (wait_sat)
  );

  // Grants are only possible in IDLE and never while reset is asserted.
  always_comb begin
    iGnt = 1'b0;
    dGnt = 1'b0;
    if (!rst && state == ARB_IDLE) begin
      if (dReq && !(iReq && wait_sat)) begin
        dGnt = 1'b1;
      end else if (iReq) begin
        iGnt = 1'b1;
      end
    end
  end

  always_comb begin
    memRdEna  = 1'b0;
    memWrEna  = 1'b0;
    memAddr   = '0;
    memWrData = '0;
    memAccess = '0;
    if (iGnt) begin
      memRdEna  = 1'b1;
      memAddr   = iAddr;
      memAccess = MEM_ACCESS_WORD;
    end else if (dGnt) begin
      memAddr   = dAddr;
      memAccess = dAccess;
      if (dWe) begin
        memWrEna  = 1'b1;
        memWrData = dWrData;
      end else begin
        memRdEna = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ARB_IDLE;
      lat_cnt <= '0;
      d_store <= 1'b0;
      iValid  <= 1'b0;
      dValid  <= 1'b0;
      iData   <= '0;
      dData   <= '0;
    end else begin
      iValid <= 1'b0;
      dValid <= 1'b0;
      case (state)
        ARB_IDLE: begin
          if (iGnt) begin
            state   <= ARB_BUSY_I;
            lat_cnt <= 3'd1;
          end else if (dGnt) begin
            state   <= ARB_BUSY_D;
            lat_cnt <= 3'd1;
            d_store <= dWe;
          end
        end
        ARB_BUSY_I, ARB_BUSY_D: begin
          // memRdData is valid in the last busy cycle; capture at its closing edge.
          if (lat_cnt == LAT) begin
            state   <= ARB_IDLE;
            lat_cnt <= '0;
            if (state == ARB_BUSY_I) begin
              iValid <= 1'b1;
              iData  <= memRdData;
            end else begin
              dValid <= 1'b1;
              if (!d_store) dData <= memRdData;
            end
          end else begin
            lat_cnt <= lat_cnt + 3'd1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  assign dbg_state = state;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (LATENCY 1 and 3) checked every
// cycle against a transaction-level model, plus directed literal scenarios.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int N        = 32;
  localparam int MAX_WAIT = 4;

  logic clk = 1'b0;
  logic rst;

  logic              i_req[2], i_gnt[2], i_valid[2];
  logic [N-1:0]      i_addr[2], i_data[2];
  logic              d_req[2], d_we[2], d_gnt[2], d_valid[2];
  logic [N-1:0]      d_addr[2], d_wdata[2], d_data[2];
  logic [2:0]        d_acc[2], mem_acc[2];
  logic              mem_rd[2], mem_wr[2];
  logic [N-1:0]      mem_addr[2], mem_wdata[2], rdata[2];
  logic [1:0]        dbg_st[2];
  logic [3:0]        dbg_wt[2];

  int n_checks = 0;
  int n_errors = 0;

  // Model state: remaining busy cycles, kind (0 fetch, 1 load, 2 store),
  // fetch wait count, and the registered outputs expected after the last edge.
  int           busy_left[2] = '{0, 0};
  int           kind[2]      = '{0, 0};
  int           wcnt[2]      = '{0, 0};
  logic         exp_iv[2]    = '{1'b0, 1'b0};
  logic         exp_dv[2]    = '{1'b0, 1'b0};
  logic [N-1:0] exp_id[2]    = '{'0, '0};
  logic [N-1:0] exp_dd[2]    = '{'0, '0};
  logic         took_i[2]    = '{1'b0, 1'b0};
  logic         took_d[2]    = '{1'b0, 1'b0};

  always #5 clk = ~clk;

  mem_port_arbiter #(.N(N), .LATENCY(1), .MAX_WAIT(MAX_WAIT)) dut1 (
    .clk(clk), .rst(rst),
    .iReq(i_req[0]), .iAddr(i_addr[0]), .iGnt(i_gnt[0]), .iValid(i_valid[0]), .iData(i_data[0]),
    .dReq(d_req[0]), .dWe(d_we[0]), .dAddr(d_addr[0]), .dWrData(d_wdata[0]), .dAccess(d_acc[0]),
    .dGnt(d_gnt[0]), .dValid(d_valid[0]), .dData(d_data[0]),
    .memRdEna(mem_rd[0]), .memWrEna(mem_wr[0]), .memAddr(mem_addr[0]), .memWrData(mem_wdata[0]),
    .memAccess(mem_acc[0]), .memRdData(rdata[0]), .dbg_state(dbg_st[0]), .dbg_wait(dbg_wt[0])
  );

  mem_port_arbiter #(.N(N), .LATENCY(3), .MAX_WAIT(MAX_WAIT)) dut3 (
    .clk(clk), .rst(rst),
    .iReq(i_req[1]), .iAddr(i_addr[1]), .iGnt(i_gnt[1]), .iValid(i_valid[1]), .iData(i_data[1]),
    .dReq(d_req[1]), .dWe(d_we[1]), .dAddr(d_addr[1]), .dWrData(d_wdata[1]), .dAccess(d_acc[1]),
    .dGnt(d_gnt[1]), .dValid(d_valid[1]), .dData(d_data[1]),
    .memRdEna(mem_rd[1]), .memWrEna(mem_wr[1]), .memAddr(mem_addr[1]), .memWrData(mem_wdata[1]),
    .memAccess(mem_acc[1]), .memRdData(rdata[1]), .dbg_state(dbg_st[1]), .dbg_wait(dbg_wt[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input int k);
    logic         eg_i, eg_d, erd, ewr;
    logic [N-1:0] ea, ewd;
    logic [2:0]   eacc;
    logic [1:0]   est;
    string        u;
    u = $sformatf("u%0d", k);
    eg_i = 1'b0;
    eg_d = 1'b0;
    if (!rst && busy_left[k] == 0) begin
      if (d_req[k] && i_req[k] && wcnt[k] == MAX_WAIT) eg_i = 1'b1;
      else if (d_req[k]) eg_d = 1'b1;
      else if (i_req[k]) eg_i = 1'b1;
    end
    erd  = eg_i || (eg_d && !d_we[k]);
    ewr  = eg_d && d_we[k];
    ea   = eg_i ? i_addr[k] : (eg_d ? d_addr[k] : '0);
    ewd  = ewr ? d_wdata[k] : '0;
    eacc = eg_i ? 3'b010 : (eg_d ? d_acc[k] : 3'b000);
    est  = (busy_left[k] == 0) ? ARB_IDLE : ((kind[k] == 0) ? ARB_BUSY_I : ARB_BUSY_D);

    chk({u, " iGnt"}, i_gnt[k], eg_i);
    chk({u, " dGnt"}, d_gnt[k], eg_d);
    chk({u, " memRdEna"}, mem_rd[k], erd);
    chk({u, " memWrEna"}, mem_wr[k], ewr);
    chk({u, " memAddr"}, mem_addr[k], ea);
    chk({u, " memWrData"}, mem_wdata[k], ewd);
    chk({u, " memAccess"}, mem_acc[k], eacc);
    chk({u, " iValid"}, i_valid[k], exp_iv[k]);
    chk({u, " iData"}, i_data[k], exp_id[k]);
    chk({u, " dValid"}, d_valid[k], exp_dv[k]);
    chk({u, " dData"}, d_data[k], exp_dd[k]);
    chk({u, " state"}, dbg_st[k], est);
    chk({u, " waitCnt"}, dbg_wt[k], wcnt[k]);

    if (rst) begin
      busy_left[k] = 0;
      wcnt[k]      = 0;
      exp_iv[k]    = 1'b0;
      exp_dv[k]    = 1'b0;
      exp_id[k]    = '0;
      exp_dd[k]    = '0;
    end else begin
      exp_iv[k] = 1'b0;
      exp_dv[k] = 1'b0;
      if (busy_left[k] > 0) begin
        if (busy_left[k] == 1) begin
          if (kind[k] == 0) begin
            exp_iv[k] = 1'b1;
            exp_id[k] = rdata[k];
          end else begin
            exp_dv[k] = 1'b1;
            if (kind[k] == 1) exp_dd[k] = rdata[k];
          end
        end
        busy_left[k]--;
      end else if (eg_i) begin
        busy_left[k] = lat_of(k);
        kind[k]      = 0;
      end else if (eg_d) begin
        busy_left[k] = lat_of(k);
        kind[k]      = d_we[k] ? 2 : 1;
      end
      if (i_req[k] && !eg_i) wcnt[k] = (wcnt[k] < MAX_WAIT) ? wcnt[k] + 1 : MAX_WAIT;
      else wcnt[k] = 0;
    end
  endtask

  task automatic check_cycle();
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      took_i[k] = i_gnt[k];
      took_d[k] = d_gnt[k];
      check_model(k);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      check_cycle();
      next_cycle();
    end
  endtask

  initial begin
    int          first_i;
    logic [15:0] gmask, vmask;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0; i_addr[k] = '0; d_req[k] = 1'b0; d_we[k] = 1'b0;
      d_addr[k] = '0; d_wdata[k] = '0; d_acc[k] = '0; rdata[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check_cycle();
    chk("reset iValid", i_valid[0], 1'b0);
    chk("reset dData", d_data[1], '0);
    chk("reset state", dbg_st[0], ARB_IDLE);
    next_cycle();
    rst = 1'b0;
    run(2);

    // Single fetch, LATENCY=1
    i_req[0] = 1'b1; i_addr[0] = 32'h10;
    check_cycle();
    chk("fetch iGnt", i_gnt[0], 1'b1);
    chk("fetch memRdEna", mem_rd[0], 1'b1);
    chk("fetch memAddr", mem_addr[0], 32'h10);
    next_cycle();
    i_req[0] = 1'b0; rdata[0] = 32'hDEADBEEF;
    run(1);
    rdata[0] = 32'h0;
    check_cycle();
    chk("fetch iValid", i_valid[0], 1'b1);
    chk("fetch iData", i_data[0], 32'hDEADBEEF);
    next_cycle();

    // Simultaneous fetch and load: data first, fetch granted with dValid
    i_req[0] = 1'b1; i_addr[0] = 32'h14;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h200; d_acc[0] = 3'b010;
    check_cycle();
    chk("tie dGnt", d_gnt[0], 1'b1);
    chk("tie iGnt", i_gnt[0], 1'b0);
    next_cycle();
    d_req[0] = 1'b0; rdata[0] = 32'hCAFEF00D;
    run(1);
    rdata[0] = 32'h0;
    check_cycle();
    chk("tie dValid", d_valid[0], 1'b1);
    chk("tie dData", d_data[0], 32'hCAFEF00D);
    chk("tie late iGnt", i_gnt[0], 1'b1);
    next_cycle();
    i_req[0] = 1'b0;
    run(3);

    // Store
    d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 32'h40; d_wdata[0] = 32'h12345678; d_acc[0] = 3'b000;
    check_cycle();
    chk("store memWrEna", mem_wr[0], 1'b1);
    chk("store memRdEna", mem_rd[0], 1'b0);
    chk("store memAddr", mem_addr[0], 32'h40);
    chk("store memWrData", mem_wdata[0], 32'h12345678);
    chk("store memAccess", mem_acc[0], 3'b000);
    next_cycle();
    d_req[0] = 1'b0; d_we[0] = 1'b0; rdata[0] = 32'h55AA55AA;
    run(1);
    check_cycle();
    chk("store dValid", d_valid[0], 1'b1);
    chk("store dData kept", d_data[0], 32'hCAFEF00D);
    next_cycle();

    // Starvation: continuous loads against a waiting fetch
    first_i = -1;
    for (int c = 0; c < 20; c++) begin
      d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = $urandom; rdata[0] = $urandom;
      i_req[0] = (first_i < 0); i_addr[0] = 32'h80;
      check_cycle();
      if (i_gnt[0] && first_i < 0) first_i = c;
      next_cycle();
    end
    chk("starve iGnt cycle", first_i, 4);
    d_req[0] = 1'b0; i_req[0] = 1'b0;
    run(4);

    // LATENCY=3 back-to-back loads
    gmask = '0; vmask = '0;
    for (int c = 0; c < 12; c++) begin
      d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 32'(c * 4); rdata[1] = $urandom;
      check_cycle();
      gmask[c] = d_gnt[1];
      vmask[c] = d_valid[1];
      next_cycle();
    end
    chk("lat3 grant cycles", gmask, 16'h0111);
    chk("lat3 valid cycles", vmask, 16'h0110);
    d_req[1] = 1'b0;
    run(6);

    // Reset during an outstanding fetch drops it; pending load granted after
    i_req[0] = 1'b1; i_addr[0] = 32'h24;
    run(1);
    i_req[0] = 1'b0; rst = 1'b1; rdata[0] = 32'hBAD0BAD0;
    d_req[0] = 1'b1; d_we[0] = 1'b0; d_addr[0] = 32'h300; d_acc[0] = 3'b010;
    run(1);
    rst = 1'b0;
    check_cycle();
    chk("rst iValid", i_valid[0], 1'b0);
    chk("rst iData", i_data[0], '0);
    chk("rst state", dbg_st[0], ARB_IDLE);
    chk("rst pending dGnt", d_gnt[0], 1'b1);
    next_cycle();
    d_req[0] = 1'b0;
    run(4);

    // Randomized traffic on both instances
    for (int k = 0; k < 2; k++) begin
      took_i[k] = 1'b0;
      took_d[k] = 1'b0;
    end
    for (int c = 0; c < 1500; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      for (int k = 0; k < 2; k++) begin
        if (!i_req[k] || took_i[k]) begin
          i_req[k]  = ($urandom_range(0, 3) != 0);
          i_addr[k] = $urandom;
        end
        if (!d_req[k] || took_d[k]) begin
          d_req[k]   = ($urandom_range(0, 3) != 0);
          d_we[k]    = 1'($urandom_range(0, 1));
          d_addr[k]  = $urandom;
          d_wdata[k] = $urandom;
          d_acc[k]   = 3'($urandom_range(0, 7));
        end
        rdata[k] = $urandom;
      end
      run(1);
    end
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_req[k] = 1'b0;
      d_req[k] = 1'b0;
    end
    run(8);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
